// File: rtl/dpram_arbiter.sv
// dpram_arbiter: round-robin arbiter/sequencer that serialises two requesters
// onto one command port of a 256x16 dual-port RAM (registered read, 1-cycle
// latency). IDLE -> ACCESS -> RESP per access, req/ack handshake.
// Optional feature macro: DPRAM_ARB_LOCK_EN (locked bursts of up to
// MAX_BURST accesses that bypass IDLE and arbitration).
module dpram_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_wr,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdat,
  output logic          a_ack,
  output logic [DW-1:0] a_rdat,
  input  logic          b_req,
  input  logic          b_wr,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdat,
  output logic          b_ack,
  output logic [DW-1:0] b_rdat,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdat,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdat,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e        state_q, state_d;
  logic          last_b_q, last_b_d;   // 1: last grant went to B
  logic          gnt_b_q, gnt_b_d;     // 1: current grant is B
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [DW-1:0] a_rdat_q, a_rdat_d;
  logic [DW-1:0] b_rdat_q, b_rdat_d;
  logic          pick_b;
  logic          chain;

`ifdef DPRAM_ARB_LOCK_EN
  localparam int unsigned BCW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [BCW-1:0] burst_q, burst_d;

  // Chain another locked access from RESP while the burst limit allows it
  always_comb begin
    chain = 1'b0;
    if (state_q == RESP && burst_q < BCW'(MAX_BURST - 1)) begin
      chain = gnt_b_q ? (b_req & b_lock) : (a_req & a_lock);
    end
  end

  // Burst counter: counts chained accesses, cleared whenever the FSM leaves RESP to IDLE
  always_comb begin
    burst_d = burst_q;
    if (state_q == RESP) begin
      burst_d = chain ? burst_q + 1'b1 : '0;
    end
  end

  // Burst counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) burst_q <= '0;
    else        burst_q <= burst_d;
  end
`else
  logic unused_lock;

  // Lock hints have no effect in this build; every access returns through IDLE
  always_comb begin
    chain       = 1'b0;
    unused_lock = ^{a_lock, b_lock, MAX_BURST[0]};
  end
`endif

  // Round-robin pick: B wins only if A is idle or A was granted last
  always_comb begin
    pick_b = b_req & (~a_req | ~last_b_q);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (a_req || b_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = chain ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch and read-data capture
  always_comb begin
    last_b_d = last_b_q;
    gnt_b_d  = gnt_b_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    a_rdat_d = a_rdat_q;
    b_rdat_d = b_rdat_q;
    if (state_q == IDLE && (a_req || b_req)) begin
      gnt_b_d  = pick_b;
      last_b_d = pick_b;
      wr_d     = pick_b ? b_wr   : a_wr;
      addr_d   = pick_b ? b_addr : a_addr;
      wdat_d   = pick_b ? b_wdat : a_wdat;
    end
    if (state_q == RESP) begin
      if (!wr_q) begin
        if (gnt_b_q) b_rdat_d = mem_rdat;
        else         a_rdat_d = mem_rdat;
      end
      if (chain) begin
        wr_d   = gnt_b_q ? b_wr   : a_wr;
        addr_d = gnt_b_q ? b_addr : a_addr;
        wdat_d = gnt_b_q ? b_wdat : a_wdat;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_q <= 1'b1;
      gnt_b_q  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
      a_rdat_q <= '0;
      b_rdat_q <= '0;
    end else begin
      last_b_q <= last_b_d;
      gnt_b_q  <= gnt_b_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      a_rdat_q <= a_rdat_d;
      b_rdat_q <= b_rdat_d;
    end
  end

  // Outputs decoded from state; RAM read data only becomes valid during RESP,
  // so it is forwarded directly while acking and held in *_rdat_q afterwards.
  always_comb begin
    busy     = (state_q != IDLE);
    mem_addr = addr_q;
    mem_wdat = wdat_q;
    mem_wr   = (state_q == ACCESS) &  wr_q;
    mem_rd   = (state_q == ACCESS) & ~wr_q;
    a_ack    = (state_q == RESP) & ~gnt_b_q;
    b_ack    = (state_q == RESP) &  gnt_b_q;
    a_rdat   = a_rdat_q;
    b_rdat   = b_rdat_q;
    if (state_q == RESP && !wr_q) begin
      if (gnt_b_q) b_rdat = mem_rdat;
      else         a_rdat = mem_rdat;
    end
  end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed self-checking bench for dpram_arbiter with a behavioural
// 256x16 registered-read RAM attached to the command port.
module tb_dpram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_wr, a_lock, b_req, b_wr, b_lock;
  logic [7:0]  a_addr, b_addr, mem_addr;
  logic [15:0] a_wdat, b_wdat, a_rdat, b_rdat, mem_wdat, mem_rdat;
  logic        a_ack, b_ack, mem_rd, mem_wr, busy;

  logic [15:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [15:0] pre_dat = '0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  dpram_arbiter #(.AW(8), .DW(16), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_wr(a_wr), .a_lock(a_lock), .a_addr(a_addr), .a_wdat(a_wdat),
    .a_ack(a_ack), .a_rdat(a_rdat),
    .b_req(b_req), .b_wr(b_wr), .b_lock(b_lock), .b_addr(b_addr), .b_wdat(b_wdat),
    .b_ack(b_ack), .b_rdat(b_rdat),
    .mem_addr(mem_addr), .mem_wdat(mem_wdat), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdat(mem_rdat), .busy(busy)
  );

  // RAM model: registered read, write on strobe, bench preload port
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_dat;
    if (mem_wr) mem[mem_addr] <= mem_wdat;
    if (mem_rd) mem_rdat <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] addr, input logic [15:0] dat);
    pre_we = 1'b1; pre_addr = addr; pre_dat = dat;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  initial begin
    logic [6:0]  order;
    int unsigned n, na, last_cyc;
    logic        first_a, b_seen;

    rst_n = 1'b0;
    a_req = 0; a_wr = 0; a_lock = 0; a_addr = '0; a_wdat = '0;
    b_req = 0; b_wr = 0; b_lock = 0; b_addr = '0; b_wdat = '0;
    @(negedge clk);
    preload(8'h20, 16'h1234);
    preload(8'h30, 16'h00AA);
    preload(8'h40, 16'h00BB);
    preload(8'h50, 16'h0000);

    // Reset state
    chk("rst_ctrl", {busy, mem_rd, mem_wr, a_ack, b_ack}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdat", mem_wdat, 0);
    chk("rst_rdat", {a_rdat, b_rdat}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // A write 0x10 = 0xBEEF
    a_req = 1; a_wr = 1; a_addr = 8'h10; a_wdat = 16'hBEEF;
    @(negedge clk);
    chk("wr_access_strobes", {mem_wr, mem_rd, a_ack, b_ack}, 4'b1000);
    chk("wr_mem_addr", mem_addr, 8'h10);
    chk("wr_mem_wdat", mem_wdat, 16'hBEEF);
    @(negedge clk);
    chk("wr_resp", {a_ack, b_ack, mem_wr, busy}, 4'b1001);
    a_req = 0;
    @(negedge clk);
    chk("wr_idle", {a_ack, busy}, 2'b00);

    // A read 0x10
    a_req = 1; a_wr = 0;
    @(negedge clk);
    chk("rd_access_strobes", {mem_wr, mem_rd}, 2'b01);
    @(negedge clk);
    chk("rd_ack", {a_ack, b_ack}, 2'b10);
    chk("rd_data", a_rdat, 16'hBEEF);
    a_req = 0;
    @(negedge clk);
    chk("rd_data_hold", a_rdat, 16'hBEEF);

    // Fresh reset, then tie held for six accesses
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    a_req = 1; a_wr = 0; a_addr = 8'h30;
    b_req = 1; b_wr = 0; b_addr = 8'h40;
    order = '0; n = 0; last_cyc = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        chk("rr_one_ack", {a_ack, b_ack} == 2'b11, 0);
        order[n] = b_ack;
        n++;
        if (n == 6) begin
          last_cyc = cyc;
          a_req = 0; b_req = 0;
          break;
        end
      end
    end
    chk("rr_count", n, 6);
    chk("rr_order", order[5:0], 6'b101010);
    chk("rr_timing", last_cyc, 17);
    chk("rr_rdat", {a_rdat, b_rdat}, {16'h00AA, 16'h00BB});
    @(negedge clk);

    // A writes 0x20 while B reads 0x20 (last grant was B, so A first)
    a_req = 1; a_wr = 1; a_addr = 8'h20; a_wdat = 16'h5555;
    b_req = 1; b_wr = 0; b_addr = 8'h20;
    n = 0; first_a = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (a_ack) begin
        chk("raw_a_rdat_hold", a_rdat, 16'h00AA);
        if (n == 0) first_a = 1;
        n++;
        a_req = 0;
      end
      if (b_ack) begin
        chk("raw_b_rdat", b_rdat, 16'h5555);
        n++;
        b_req = 0;
      end
      if (n == 2) break;
    end
    chk("raw_done", n, 2);
    chk("raw_a_first", first_a, 1);
    @(negedge clk);

    // Reset during ACCESS of an A write (last grant is B before reset)
    a_req = 1; a_wr = 1; a_addr = 8'h50; a_wdat = 16'h7777;
    @(negedge clk);
    chk("abort_pre_wr", mem_wr, 1);
    #2 rst_n = 0;
    #1;
    chk("abort_async_drop", {mem_wr, mem_rd, busy}, 3'b000);
    a_req = 0;
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      chk("abort_no_ack", {a_ack, b_ack}, 2'b00);
    end
    rst_n = 1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_no_write", mem[8'h50], 16'h0000);
    a_req = 1; a_wr = 0; a_addr = 8'h30;
    b_req = 1; b_wr = 0; b_addr = 8'h40;
    @(negedge clk);
    @(negedge clk);
    chk("abort_tie_a", {a_ack, b_ack}, 2'b10);
    a_req = 0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_tie_b_next", {a_ack, b_ack}, 2'b01);
    b_req = 0;
    @(negedge clk);

    // B drops req right after grant; access must still complete once
    b_req = 1; b_wr = 0; b_addr = 8'h40;
    n = 0; b_seen = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      b_req = 0;
      if (b_ack) begin
        n++;
        if (!b_seen) chk("drop_rdat", b_rdat, 16'h00BB);
        b_seen = 1;
      end
    end
    chk("drop_ack_once", n, 1);

    // A locked reads (6 accesses) while B has one pending read
    a_req = 1; a_wr = 0; a_lock = 1; a_addr = 8'h30;
    b_req = 1; b_wr = 0; b_addr = 8'h40;
    order = '0; n = 0; na = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        order[n] = b_ack;
        n++;
        if (a_ack) na++;
        if (b_ack) b_req = 0;
        if (na == 6) begin
          a_req = 0; a_lock = 0;
        end
        if (n == 7) break;
      end
    end
    chk("lock_count", n, 7);
`ifdef DPRAM_ARB_LOCK_EN
    chk("lock_order", order, 7'b0010000);
`else
    chk("lock_order", order, 7'b0000010);
`endif
    @(negedge clk);
    chk("end_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
